wb_ctrl_pipe: RTL and testbench

WB_CTRL_PIPE -- requirements
Module: wb_ctrl_pipe

---
 rtl/wb_ctrl_pipe.sv | 164 ++++++++++++++++
 tb/tb_wb_ctrl_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pipe.sv
// RV32I writeback-control decoder and pipeline: decodes RegWEn/WBSel/rd in decode,
// carries them through STAGES registers with stall/flush, and flags load-use hazards.
module wb_ctrl_pipe #(
  parameter int STAGES = 3,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              stall,
  input  logic [STAGES-1:0] flush,
  output logic              id_illegal,
  output logic              load_use,
  output logic              wb_valid,
  output logic              wb_regwen,
  output logic [1:0]        wb_wbsel,
  output logic [RD_W-1:0]   wb_rd,
  output logic [7:0]        illegal_cnt
);

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wbsel_e;

  typedef struct packed {
    logic            valid;
    logic            regwen;
    wbsel_e          wbsel;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } stage_t;

  localparam stage_t BUBBLE = stage_t'('0);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f, rs1_f, rs2_f;

  assign opcode = id_instr[6:0];
  assign rd_f   = id_instr[11:7];
  assign funct3 = id_instr[14:12];
  assign rs1_f  = id_instr[19:15];
  assign rs2_f  = id_instr[24:20];
  assign funct7 = id_instr[31:25];

  logic   dec_legal;
  logic   dec_regwen;
  wbsel_e dec_wbsel;
  logic   uses_rs1, uses_rs2;
  stage_t dec_stage;
  stage_t pipe [STAGES];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_legal  = 1'b0;
    dec_regwen = 1'b1;
    dec_wbsel  = WB_MEM;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_wbsel = WB_ALU;
      end
      OPC_JAL: begin
        dec_legal = 1'b1;
        dec_wbsel = WB_PC4;
      end
      OPC_JALR: begin
        dec_legal = (funct3 == 3'b000);
        dec_wbsel = WB_PC4;
      end
      OPC_LOAD: dec_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OPC_STORE: begin
        dec_legal  = funct3 inside {3'b000, 3'b001, 3'b010};
        dec_regwen = 1'b0;
      end
      OPC_BRANCH: begin
        dec_legal  = !(funct3 inside {3'b010, 3'b011});
        dec_regwen = 1'b0;
      end
      OPC_OPIMM: begin
        dec_wbsel = WB_ALU;
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'b0000000);
          3'b101:  dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: dec_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec_wbsel = WB_ALU;
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_FENCE: begin
        dec_legal  = (funct3 == 3'b000);
        dec_regwen = 1'b0;
      end
      OPC_SYSTEM: begin
        // Only ecall and ebreak; CSR ops are outside the base ISA.
        dec_legal  = (id_instr[31:7] == 25'd0) || (id_instr[31:7] == {12'h001, 13'd0});
        dec_regwen = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_regwen = 1'b0;
      dec_wbsel  = WB_MEM;
    end
    if (rd_f == 5'd0) dec_regwen = 1'b0;
  end

  assign id_illegal = !dec_legal;
  assign uses_rs1   = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign uses_rs2   = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

  assign dec_stage = '{valid:   id_valid,
                       regwen:  dec_regwen,
                       wbsel:   dec_wbsel,
                       rd:      RD_W'(rd_f),
                       illegal: !dec_legal};

  assign load_use = id_valid && pipe[0].valid && pipe[0].regwen && (pipe[0].wbsel == WB_MEM) &&
                    ((uses_rs1 && (pipe[0].rd == RD_W'(rs1_f))) ||
                     (uses_rs2 && (pipe[0].rd == RD_W'(rs2_f))));

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole stage array is reset, not just valid, so every wb_* field reads 0 in reset.
      for (int i = 0; i < STAGES; i++) pipe[i] <= BUBBLE;
      illegal_cnt <= 8'd0;
    end else begin
      if (flush[0])    pipe[0] <= BUBBLE;
      else if (!stall) pipe[0] <= dec_stage;
      for (int i = 1; i < STAGES; i++) begin
        if (flush[i] || (i == 1 && stall)) pipe[i] <= BUBBLE;
        else                               pipe[i] <= pipe[i-1];
      end
      if (pipe[STAGES-1].valid && pipe[STAGES-1].illegal && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  assign wb_valid  = pipe[STAGES-1].valid;
  assign wb_regwen = pipe[STAGES-1].valid && pipe[STAGES-1].regwen;
  assign wb_wbsel  = pipe[STAGES-1].wbsel;
  assign wb_rd     = pipe[STAGES-1].rd;

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed bench for wb_ctrl_pipe (STAGES=3): decode, latency, stall, flush,
// load-use detection, illegal counter saturation and mid-flight reset.
module tb_wb_ctrl_pipe;

  localparam logic [31:0] ADD_X3   = 32'h002081B3;
  localparam logic [31:0] ADD_X7   = 32'h002083B3;
  localparam logic [31:0] LW_X5    = 32'h0000A283;
  localparam logic [31:0] ADD_RS1  = 32'h00128333;
  localparam logic [31:0] ADD_RS2  = 32'h00508333;
  localparam logic [31:0] LUI_X6   = 32'h00028337;
  localparam logic [31:0] JAL_X1   = 32'h008000EF;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] SW       = 32'h0050A023;
  localparam logic [31:0] ALL_ONES = 32'hFFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        stall;
  logic [2:0]  flush;
  logic        id_illegal;
  logic        load_use;
  logic        wb_valid;
  logic        wb_regwen;
  logic [1:0]  wb_wbsel;
  logic [4:0]  wb_rd;
  logic [7:0]  illegal_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  wb_ctrl_pipe #(.STAGES(3), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .stall(stall), .flush(flush), .id_illegal(id_illegal), .load_use(load_use),
    .wb_valid(wb_valid), .wb_regwen(wb_regwen), .wb_wbsel(wb_wbsel),
    .wb_rd(wb_rd), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr);
    id_instr = instr;
    id_valid = 1'b1;
  endtask

  task automatic idle();
    id_instr = NOP;
    id_valid = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic we,
                          input logic [1:0] sel, input logic [4:0] rd);
    check({tag, "_valid"}, 32'(wb_valid), 32'(v));
    check({tag, "_regwen"}, 32'(wb_regwen), 32'(we));
    check({tag, "_wbsel"}, 32'(wb_wbsel), 32'(sel));
    check({tag, "_rd"}, 32'(wb_rd), 32'(rd));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 3'b000;
    idle();
    #3;
    check_wb("reset", 1'b0, 1'b0, 2'b00, 5'd0);
    check("reset_cnt", 32'(illegal_cnt), 32'd0);
    #9 rst_n = 1'b1;

    // Combinational decode
    id_instr = ALL_ONES;      #1 check("ill_ones", 32'(id_illegal), 32'd1);
    id_instr = 32'h00000000;  #1 check("ill_zero", 32'(id_illegal), 32'd1);
    id_instr = 32'h202081B3;  #1 check("ill_r_f7", 32'(id_illegal), 32'd1);
    id_instr = 32'h402081B3;  #1 check("sub_ok", 32'(id_illegal), 32'd0);
    id_instr = 32'h4010D093;  #1 check("srai_ok", 32'(id_illegal), 32'd0);
    id_instr = 32'h40109093;  #1 check("slli_f7", 32'(id_illegal), 32'd1);
    id_instr = 32'h00000073;  #1 check("ecall_ok", 32'(id_illegal), 32'd0);

    // add x3,x1,x2: three-edge latency
    issue(ADD_X3); #1 check("add_dec", 32'(id_illegal), 32'd0);
    tick(); idle();
    check("add_e1", 32'(wb_valid), 32'd0);
    tick(); check("add_e2", 32'(wb_valid), 32'd0);
    tick(); check_wb("add_e3", 1'b1, 1'b1, 2'b01, 5'd3);
    tick(); check("add_e4", 32'(wb_valid), 32'd0);

    // lw x5 followed by dependent add, one stall cycle
    issue(LW_X5); tick();
    issue(ADD_X7);  #1 check("lu_none", 32'(load_use), 32'd0);
    issue(ADD_RS1); #1 check("lu_rs1", 32'(load_use), 32'd1);
    issue(ADD_RS2); #1 check("lu_rs2", 32'(load_use), 32'd1);
    issue(LUI_X6);  #1 check("lu_lui", 32'(load_use), 32'd0);
    id_instr = ADD_RS1; id_valid = 1'b0;
    #1 check("lu_novalid", 32'(load_use), 32'd0);
    issue(ADD_RS1); stall = 1'b1;
    tick(); stall = 1'b0;
    check("stall_e2", 32'(wb_valid), 32'd0);
    tick(); idle();
    check("stall_e3", 32'(wb_valid), 32'd0);
    tick(); check_wb("lw_wb", 1'b1, 1'b1, 2'b00, 5'd5);
    tick(); check_wb("dep_add_wb", 1'b1, 1'b1, 2'b01, 5'd6);

    // jal killed at stage 0, then jal unflushed
    issue(JAL_X1); flush = 3'b001;
    tick(); flush = 3'b000; idle();
    tick(); tick();
    check("jal_flushed_v", 32'(wb_valid), 32'd0);
    check("jal_flushed_we", 32'(wb_regwen), 32'd0);
    issue(JAL_X1); tick(); idle(); tick(); tick();
    check_wb("jal_wb", 1'b1, 1'b1, 2'b10, 5'd1);

    // flush[2] kills the last stage
    issue(ADD_X3); tick(); idle(); tick();
    flush = 3'b100; tick(); flush = 3'b000;
    check("flush2", 32'(wb_valid), 32'd0);

    // flush[0] wins over stall hold
    issue(ADD_X3); tick();
    stall = 1'b1; flush = 3'b001; tick();
    stall = 1'b0; flush = 3'b000; idle();
    tick(); tick();
    check("flush_over_hold", 32'(wb_valid), 32'd0);

    // nop and sw
    issue(NOP); tick(); issue(SW); tick(); idle(); tick();
    check_wb("nop_wb", 1'b1, 1'b0, 2'b01, 5'd0);
    tick();
    check("sw_valid", 32'(wb_valid), 32'd1);
    check("sw_regwen", 32'(wb_regwen), 32'd0);
    check("sw_wbsel", 32'(wb_wbsel), 32'd0);

    // Illegal counter
    tick();
    check("cnt_start", 32'(illegal_cnt), 32'd0);
    issue(ALL_ONES); tick(); idle(); tick(); tick();
    check("ill_wb_valid", 32'(wb_valid), 32'd1);
    check("ill_wb_regwen", 32'(wb_regwen), 32'd0);
    check("ill_wb_wbsel", 32'(wb_wbsel), 32'd0);
    check("cnt_before", 32'(illegal_cnt), 32'd0);
    tick();
    check("cnt_one", 32'(illegal_cnt), 32'd1);
    issue(ALL_ONES);
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 256) check("cnt_254", 32'(illegal_cnt), 32'd254);
      if (n == 257) check("cnt_255", 32'(illegal_cnt), 32'd255);
    end
    check("cnt_stream", 32'(illegal_cnt), 32'd255);
    idle();
    for (int n = 0; n < 4; n++) tick();
    check("cnt_sat", 32'(illegal_cnt), 32'd255);

    // Reset with three instructions in flight
    issue(ADD_X3); tick(); tick(); tick();
    check("inflight_valid", 32'(wb_valid), 32'd1);
    #2 rst_n = 1'b0; idle();
    #1;
    check_wb("midreset", 1'b0, 1'b0, 2'b00, 5'd0);
    check("midreset_cnt", 32'(illegal_cnt), 32'd0);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("post_reset_we", 32'(wb_regwen), 32'd0);
      check("post_reset_v", 32'(wb_valid), 32'd0);
    end
    issue(ADD_X3); tick(); idle(); tick();
    check("first_e2", 32'(wb_valid), 32'd0);
    tick();
    check_wb("first_e3", 1'b1, 1'b1, 2'b01, 5'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
